ahb_zbt_sram_ctrl: RTL and testbench

Parametrised AHB-Lite slave controlling an external ZBT SSRAM, in either flow-through or pipelined mode. It generalises the existing 32-bit zero-wait controller in four ways: configurable data width, configurable address width and SRAM read latency, read wait-state insertion, and a two-cycle ERROR response for illegal transfer sizes. It sits between the AHB S->M mux and the board-level SSRAM pads; tristate buffering is done at top level.

---
 rtl/ahb_zbt_sram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ahb_zbt_sram_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_zbt_sram_ctrl.sv
// AHB-Lite slave driving a ZBT SSRAM in flow-through or pipelined mode.
// Width, address span and read latency are parameters; oversize gets ERROR.
module ahb_zbt_sram_ctrl #(
    parameter int DW     = 32,
    parameter int AW     = 20,
    parameter int RD_LAT = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic                    HREADYIn,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic                    HWRITE,
    input  logic [31:0]             HADDR,
    input  logic [DW-1:0]           HWDATA,
    output logic [DW-1:0]           HRDATA,
    output logic                    HREADYOut,
    output logic [1:0]              HRESP,
    output logic                    SCLK,
    output logic [AW-$clog2(DW/8)-1:0] SADDR,
    output logic                    SnCE,
    output logic                    SnWR,
    output logic [DW/8-1:0]         SnWBYTE,
    output logic                    SADVnLD,
    output logic                    SMODE,
    output logic                    SnCKE,
    output logic                    SnOE,
    output logic                    SDATAEN,
    output logic [DW-1:0]           SWDATA,
    input  logic [DW-1:0]           SRDATA
);

    localparam int NB = DW / 8;
    localparam int BL = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RWAIT,
        S_RD,
        S_WR,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_dec;
    logic            w_valid;
    logic            w_illegal;
    logic            w_cmd;
    logic [7:0]      w_szb;
    logic [BL-1:0]   w_off;
    logic            w_ready;
    logic [1:0]      w_resp;
    logic            w_unused;

    assign w_unused  = &{1'b0, HTRANS[0], HADDR[31:AW]};

    assign w_valid   = HSEL & HREADYIn & HTRANS[1];
    assign w_szb     = 8'(1) << HSIZE;
    assign w_illegal = w_valid & (w_szb > 8'(NB));
    assign w_cmd     = w_valid & ~w_illegal & ~HRESET;

    // lane base is the byte offset aligned down to the transfer size
    assign w_off = HADDR[BL-1:0] & ~(w_szb[BL-1:0] - BL'(1));

    assign SCLK    = HCLK;
    assign SADDR   = HADDR[AW-1:BL];
    assign SnCE    = ~w_cmd;
    assign SnWR    = ~(w_cmd & HWRITE);
    assign SADVnLD = 1'b0;
    assign SMODE   = 1'b0;
    assign SnCKE   = 1'b0;
    assign SnOE    = SDATAEN;
    assign HRDATA  = SRDATA;

    always_comb begin
        SnWBYTE = '1;
        for (int i = 0; i < NB; i++) begin
            if (w_cmd && HWRITE &&
                i >= int'(w_off) &&
                i < int'(w_off) + int'(w_szb)) begin
                SnWBYTE[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_dec = S_IDLE;
        if (w_valid && w_illegal) begin
            w_dec = S_ERR1;
        end else if (w_valid && !HWRITE) begin
            w_dec = (RD_LAT == 2) ? S_RWAIT : S_RD;
        end else if (w_valid && HWRITE) begin
            w_dec = S_WR;
        end
    end

    always_comb begin
        w_next  = w_dec;
        w_ready = 1'b1;
        w_resp  = 2'b00;
        unique case (r_state)
            S_RWAIT: begin
                w_ready = 1'b0;
                w_next  = S_RD;
            end
            S_ERR1: begin
                w_ready = 1'b0;
                w_resp  = 2'b01;
                w_next  = S_ERR2;
            end
            S_ERR2: begin
                w_resp  = 2'b01;
            end
            default: begin
                w_next  = w_dec;
            end
        endcase
    end

    assign HREADYOut = w_ready;
    assign HRESP     = w_resp;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_ft
            assign SDATAEN = (r_state == S_WR);
            assign SWDATA  = SDATAEN ? HWDATA : '0;
        end else begin : g_pl
            logic          r_den;
            logic [DW-1:0] r_wdata;

            // one extra stage so write data lands with the SRAM's data slot
            always_ff @(posedge HCLK) begin
                if (HRESET) begin
                    r_den   <= 1'b0;
                    r_wdata <= '0;
                end else begin
                    r_den <= (r_state == S_WR);
                    if (r_state == S_WR) begin
                        r_wdata <= HWDATA;
                    end
                end
            end

            assign SDATAEN = r_den;
            assign SWDATA  = r_wdata;
        end
    endgenerate

endmodule

// File: tb/tb_ahb_zbt_sram_ctrl.sv
// Bench for ahb_zbt_sram_ctrl: three configurations, each with an SSRAM
// model, driven by directed and random AHB traffic against a byte-level model.
module tb_ahb_zbt_sram_ctrl;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [63:0] hwdata;
    int          cur = 0;
    logic        hready_in;

    logic [63:0] hrdata_a [3];
    logic [63:0] swdata_a [3];
    logic        hready_a [3];
    logic [1:0]  hresp_a  [3];
    logic        sce_a    [3];
    logic        swr_a    [3];
    logic        sden_a   [3];
    logic        soe_a    [3];
    logic [7:0]  swbyte_a [3];
    logic [19:0] saddr_a  [3];
    logic [3:0]  tie_a    [3];
    int          err_a    [3];

    assign hready_in = hready_a[cur];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DWG  = (g == 2) ? 64 : 32;
        localparam int LATG = (g == 1) ? 1 : 2;
        localparam int NBG  = DWG / 8;
        localparam int SWG  = 20 - $clog2(NBG);

        logic [DWG-1:0] hrdata, swdata, srdata, junk;
        logic [1:0]     hresp;
        logic           hready, sclk, sce, swr, advld, smode, scke, soe, sden;
        logic [NBG-1:0] swbyte;
        logic [SWG-1:0] saddr;

        ahb_zbt_sram_ctrl #(.DW(DWG), .AW(20), .RD_LAT(LATG)) u_dut (
            .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && (cur == g)),
            .HREADYIn(hready_in), .HTRANS(htrans), .HSIZE(hsize),
            .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata[DWG-1:0]),
            .HRDATA(hrdata), .HREADYOut(hready), .HRESP(hresp),
            .SCLK(sclk), .SADDR(saddr), .SnCE(sce), .SnWR(swr),
            .SnWBYTE(swbyte), .SADVnLD(advld), .SMODE(smode),
            .SnCKE(scke), .SnOE(soe), .SDATAEN(sden),
            .SWDATA(swdata), .SRDATA(srdata)
        );

        // SSRAM model: command captured on the edge, data slot LATG edges later
        logic [DWG-1:0] mem [256];
        logic           init_done = 1'b0;
        logic           v1, w1, v2, w2, dv, dw;
        logic [NBG-1:0] b1, b2, db;
        logic [7:0]     a1, a2, da;
        int             err = 0;

        assign dv = (LATG == 1) ? v1 : v2;
        assign dw = (LATG == 1) ? w1 : w2;
        assign db = (LATG == 1) ? b1 : b2;
        assign da = (LATG == 1) ? a1 : a2;
        assign srdata = (dv && !dw) ? mem[da] : junk;

        always @(posedge HCLK) begin
            junk <= DWG'({$urandom, $urandom});
            if (!init_done) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
                init_done <= 1'b1;
            end
            if (HRESET) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
            end else begin
                v1 <= !sce;
                w1 <= !swr;
                b1 <= ~swbyte;
                a1 <= saddr[7:0];
                v2 <= v1;
                w2 <= w1;
                b2 <= b1;
                a2 <= a1;
                if (dv && dw) begin
                    if (sden !== 1'b1) err <= err + 1;
                    for (int i = 0; i < NBG; i++)
                        if (db[i]) mem[da][8*i +: 8] <= swdata[8*i +: 8];
                end else if (sden !== 1'b0) begin
                    err <= err + 1;
                end
            end
        end

        assign hrdata_a[g] = 64'(hrdata);
        assign swdata_a[g] = 64'(swdata);
        assign hready_a[g] = hready;
        assign hresp_a[g]  = hresp;
        assign sce_a[g]    = sce;
        assign swr_a[g]    = swr;
        assign sden_a[g]   = sden;
        assign soe_a[g]    = soe;
        assign swbyte_a[g] = 8'(swbyte);
        assign saddr_a[g]  = 20'(saddr);
        assign tie_a[g]    = {sclk ^ HCLK, advld, smode, scke};
        assign err_a[g]    = err;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  refm [3][1024];
    logic        dp_v, dp_w, dp_ill;
    int          dp_waits;
    logic [63:0] dp_exp;
    logic [63:0] last_rdata;
    logic        last_sce;
    logic [7:0]  last_wbyte;
    logic [19:0] last_saddr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one AHB address phase, holding it until the prior data phase ends
    task automatic step(input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] ad,
                        input logic [63:0] wd);
        int w, nb, szb, off, base;
        logic done, rdy, vld, ill, cmd;
        logic [7:0] ewb;
        logic [63:0] er;
        nb   = (cur == 2) ? 8 : 4;
        szb  = 1 << sz;
        off  = (int'(ad) % nb) & ~(szb - 1);
        base = int'(ad) & ~(nb - 1);
        hsel = 1'b1; htrans = tr; hwrite = wr; hsize = sz; haddr = ad;
        w = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge HCLK);
            rdy = (w >= dp_waits);
            chk("hready", 64'(hready_in), 64'(rdy));
            chk("hresp", 64'(hresp_a[cur]), dp_ill ? 64'd1 : 64'd0);
            if (rdy && dp_v && !dp_w && !dp_ill) begin
                chk("hrdata", hrdata_a[cur], dp_exp);
                last_rdata = hrdata_a[cur];
            end
            vld = rdy && tr[1];
            ill = vld && (szb > nb);
            cmd = vld && !ill;
            ewb = 8'((1 << nb) - 1);
            if (cmd && wr) ewb = ewb & ~8'(((1 << szb) - 1) << off);
            chk("snce", 64'(sce_a[cur]), 64'(!cmd));
            chk("snwr", 64'(swr_a[cur]), 64'(!(cmd && wr)));
            chk("snwbyte", 64'(swbyte_a[cur]), 64'(ewb));
            if (cmd)
                chk("saddr", 64'(saddr_a[cur]),
                    64'(ad[19:0] >> ((nb == 8) ? 3 : 2)));
            last_sce   = sce_a[cur];
            last_wbyte = swbyte_a[cur];
            last_saddr = saddr_a[cur];
            done = rdy;
            w++;
            @(posedge HCLK);
            #1;
        end
        dp_v     = tr[1];
        dp_w     = wr;
        dp_ill   = tr[1] && (szb > nb);
        dp_waits = dp_ill ? 1 : ((tr[1] && !wr && cur != 1) ? 1 : 0);
        hwdata   = wd;
        if (tr[1] && !dp_ill) begin
            if (wr) begin
                for (int i = off; i < off + szb; i++)
                    refm[cur][base + i] = wd[8*i +: 8];
            end else begin
                er = '0;
                for (int i = 0; i < nb; i++)
                    er[8*i +: 8] = refm[cur][base + i];
                dp_exp = er;
            end
        end
    endtask

    task automatic idle();
        step(2'd0, 1'b0, 3'd0, 32'h0, 64'h0);
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++) begin
            int r, maxs;
            logic [1:0] tr;
            logic [2:0] sz;
            logic [31:0] ad;
            r    = $urandom_range(0, 11);
            tr   = (r < 2) ? 2'd0 : (r == 2) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            maxs = (cur == 2) ? 3 : 2;
            sz   = 3'($urandom_range(0, maxs));
            if ($urandom_range(0, 11) == 0) sz = 3'(maxs + 1);
            ad   = 32'($urandom_range(0, 511)) & ~((32'd1 << sz) - 32'd1);
            step(tr, 1'($urandom_range(0, 1)), sz, ad, {$urandom, $urandom});
        end
        idle();
        idle();
    endtask

    task automatic chk_reset_state(input int g, input string tag);
        chk({tag, "_hready"}, 64'(hready_a[g]), 64'd1);
        chk({tag, "_hresp"}, 64'(hresp_a[g]), 64'd0);
        chk({tag, "_sdataen"}, 64'(sden_a[g]), 64'd0);
        chk({tag, "_snoe"}, 64'(soe_a[g]), 64'd0);
        chk({tag, "_snce"}, 64'(sce_a[g]), 64'd1);
        chk({tag, "_swdata"}, swdata_a[g], 64'd0);
        chk({tag, "_ties"}, 64'(tie_a[g]), 64'd0);
    endtask

    // reset lands in the data phase of a read (RWAIT) or write (WR)
    task automatic rst_mid(input logic wr, input string tag);
        step(2'd2, wr, 3'd2, 32'h3F0, {$urandom, $urandom});
        HRESET = 1'b1;
        hsel   = 1'b0;
        htrans = 2'd0;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk_reset_state(cur, tag);
        dp_v = 1'b0; dp_w = 1'b0; dp_ill = 1'b0; dp_waits = 0;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; hsel = 1'b0; htrans = 2'd0; hsize = 3'd0;
        hwrite = 1'b0; haddr = 32'h0; hwdata = 64'h0;
        dp_v = 1'b0; dp_w = 1'b0; dp_ill = 1'b0; dp_waits = 0;
        dp_exp = '0; last_rdata = '0;
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 1024; i++) refm[g][i] = 8'h00;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        for (int g = 0; g < 3; g++) chk_reset_state(g, "por");
        @(posedge HCLK);
        #1;

        cur = 0;
        step(2'd2, 1'b1, 3'd2, 32'h100, 64'hDEADBEEF);
        chk("tp_wr_snce", 64'(last_sce), 64'd0);
        chk("tp_wr_wbyte", 64'(last_wbyte), 64'h0);
        chk("tp_wr_saddr", 64'(last_saddr), 64'h40);
        step(2'd2, 1'b0, 3'd2, 32'h100, 64'h0);
        idle();
        chk("tp_rd_data", last_rdata, 64'hDEADBEEF);
        step(2'd2, 1'b1, 3'd0, 32'h101, 64'h0000_0000_0000_A500);
        chk("tp_b101", 64'(last_wbyte), 64'h0D);
        step(2'd2, 1'b1, 3'd0, 32'h102, 64'h0000_0000_0077_0000);
        chk("tp_b102", 64'(last_wbyte), 64'h0B);
        step(2'd2, 1'b1, 3'd1, 32'h102, 64'h0000_0000_1234_0000);
        chk("tp_h102", 64'(last_wbyte), 64'h03);
        step(2'd2, 1'b0, 3'd2, 32'h100, 64'h0);
        idle();
        chk("tp_merge", last_rdata, 64'h1234_A5EF);
        step(2'd2, 1'b0, 3'd3, 32'h0, 64'h0);
        chk("tp_err_snce", 64'(last_sce), 64'd1);
        idle();
        idle();
        step(2'd1, 1'b0, 3'd2, 32'h40, 64'h0);
        chk("tp_busy_snce", 64'(last_sce), 64'd1);
        idle();
        rand_run(60);

        cur = 1;
        step(2'd2, 1'b0, 3'd2, 32'h10, 64'h0);
        step(2'd2, 1'b1, 3'd2, 32'h14, 64'h0000_0000_C0FF_EE11);
        step(2'd2, 1'b0, 3'd2, 32'h14, 64'h0);
        idle();
        chk("ft_rd_data", last_rdata, 64'hC0FF_EE11);
        rand_run(60);

        cur = 2;
        step(2'd2, 1'b1, 3'd0, 32'h7, 64'h9A00_0000_0000_0000);
        chk("w64_b7", 64'(last_wbyte), 64'h7F);
        chk("w64_saddr0", 64'(last_saddr), 64'h0);
        step(2'd2, 1'b1, 3'd3, 32'h3F8, 64'h0123_4567_89AB_CDEF);
        chk("w64_saddr", 64'(last_saddr), 64'h7F);
        step(2'd2, 1'b0, 3'd3, 32'h3F8, 64'h0);
        idle();
        chk("w64_rd_data", last_rdata, 64'h0123_4567_89AB_CDEF);
        step(2'd2, 1'b0, 3'd3, 32'h0, 64'h0);
        idle();
        chk("w64_rd_b7", last_rdata, 64'h9A00_0000_0000_0000);
        rand_run(60);

        cur = 0;
        rst_mid(1'b0, "rst_rwait");
        rst_mid(1'b1, "rst_wdrop");
        step(2'd2, 1'b0, 3'd2, 32'h100, 64'h0);
        idle();
        chk("post_rst_rd", last_rdata, 64'h1234_A5EF);

        for (int g = 0; g < 3; g++) chk("sram_slot", 64'(err_a[g]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
